// File: rtl/bcd_to_binary.sv
// Packed-BCD to unsigned binary converter using reverse double-dabble
// (shift right one bit, then subtract 3 from every BCD nibble >= 8).
module bcd_to_binary #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [4*DIGITS-1:0]   BCDIN,
  output logic [BIN_W-1:0]      BINOUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic [2:0]            o_dbg_state
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_SHIFT = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [SR_W-1:0]     r_sr;
  logic [SR_W-1:0]     w_corr;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIN_W-1:0]    r_binout;
  logic                r_done;
  logic                r_err;
  logic                w_bad;
  logic                w_last;

  // Handshake: START is sampled only in IDLE and ignored while BUSY; DONE is
  // a one-cycle pulse, with BINOUT/ERR valid from that cycle until the next accept.
  assign BUSY        = (r_state != S_IDLE);
  assign DONE        = r_done;
  assign ERR         = r_err;
  assign BINOUT      = r_binout;
  assign o_dbg_state = r_state;
  assign w_last      = (r_cnt == CNT_W'(BIN_W));

  // Per-nibble digit check and subtract-3 correction; nibbles never interact.
  always_comb begin
    w_corr = r_sr;
    w_bad  = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_sr[BIN_W + 4*d +: 4] > 4'd9) w_bad = 1'b1;
      if (r_sr[BIN_W + 4*d +: 4] >= 4'd8)
        w_corr[BIN_W + 4*d +: 4] = r_sr[BIN_W + 4*d +: 4] - 4'd3;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (START) w_next = S_INIT;
      S_INIT:  w_next = w_bad ? S_DONE : S_SHIFT;
      S_SHIFT: w_next = S_CHECK;
      S_CHECK: w_next = w_last ? S_DONE : S_SHIFT;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_sr     <= '0;
      r_cnt    <= '0;
      r_binout <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (START) begin
            r_sr  <= {BCDIN, {BIN_W{1'b0}}};
            r_cnt <= '0;
            r_err <= 1'b0;
          end
        end
        S_INIT: begin
          if (w_bad) r_err <= 1'b1;
        end
        S_SHIFT: begin
          r_sr  <= r_sr >> 1;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_CHECK: begin
          // The final shift leaves the binary field complete; no correction after it.
          if (!w_last) r_sr <= w_corr;
        end
        S_DONE: begin
          if (!r_err) r_binout <= r_sr[BIN_W-1:0];
          r_done <= 1'b1;
          r_sr   <= '0;
          r_cnt  <= '0;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Multi-cycle converter from packed BCD to unsigned binary using the reverse double-dabble (shift-right, subtract-3) algorithm.
- It is the inverse of our binary-to-BCD converter. It turns keypad- or display-entered decimal values back into binary for the datapath, e.g. joystick thresholds and set-points.
- START/BUSY/DONE handshake; an invalid BCD digit is flagged rather than converted.

Parameters:
- DIGITS, 4, number of BCD digits in BCDIN.
- BIN_W, 14, binary output width. Must satisfy 2^BIN_W > 10^DIGITS - 1; 14 covers 9999.

Ports:
- CLK  input  1  system clock (100 MHz).
- RST  input  1  synchronous, active-low reset; RST == 0 at a rising CLK edge resets the block.
- START  input  1  request conversion; sampled only in IDLE.
- BCDIN  input  4*DIGITS  packed BCD. [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- BINOUT  output  BIN_W  converted binary result; held between conversions.
- BUSY  output  1  high whenever STATE != IDLE.
- DONE  output  1  one-cycle pulse when a conversion (or rejection) completes.
- ERR  output  1  high if the last accepted request contained a digit > 9.

Behaviour:
- Reset (RST == 0 at posedge CLK): BINOUT = 0, DONE = 0, ERR = 0, BUSY = 0, STATE = IDLE, shift register and shift count cleared.
  - Reset mid-conversion aborts immediately; no DONE is produced for the aborted request.
- Working register tmpSR is 4*DIGITS + BIN_W bits (30 by default): BCD field in the upper bits, binary field in the lower BIN_W bits.
- States are IDLE, INIT, SHIFT, CHECK and DONE_ST.
- IDLE:
  - DONE <= 0.
  - On START == 1: tmpSR <= {BCDIN, BIN_W'b0}, shift count <= 0, ERR <= 0, go to INIT.
  - BCDIN is captured only at this edge; later changes to BCDIN are ignored.
- INIT:
  - If any captured nibble > 9: set flag ERR <= 1 and go to DONE_ST.
  - Otherwise go to SHIFT.
- SHIFT: tmpSR <= tmpSR >> 1 (zero fill at MSB); shift count += 1; go to CHECK.
- CHECK:
  - If shift count == BIN_W: go to DONE_ST with no correction.
  - Else, for every BCD nibble of tmpSR, in parallel: if nibble >= 8, nibble <= nibble - 3. Then go to SHIFT.
- DONE_ST:
  - If ERR == 0: BINOUT <= tmpSR[BIN_W-1:0]. If ERR == 1: BINOUT holds its previous value.
  - DONE <= 1; clear tmpSR and shift count; go to IDLE.
- Latency, valid request (START sampled at edge e0):
  - INIT at e1; shift k at e(2k); check k at e(2k+1).
  - DONE_ST executes at e(2*BIN_W+2), i.e. e30 by default.
  - BINOUT and DONE are visible 30 cycles after e0; DONE falls at e31.
  - Next START is accepted at e31 or later.
- Latency, invalid request: DONE and ERR are visible after e2. ERR stays high until the next START is accepted or reset.
- START while BUSY: ignored, not queued.
- START held high continuously: back-to-back conversions every 31 cycles.
- Arithmetic: the subtract-3 on a nibble >= 8 never underflows. No carries cross nibble boundaries.

Test Plan:
- Reset, then START with BCDIN = 16'h1234 -> BINOUT = 14'd1234 (0x04D2), DONE pulses exactly one cycle 30 clocks after START, BUSY high for those 30 cycles, ERR = 0.
- Boundary values, one request each: BCDIN = 16'h9999 -> BINOUT = 14'h270F; BCDIN = 16'h0000 -> BINOUT = 0; BCDIN = 16'h0001 -> BINOUT = 1.
- After a valid conversion of 16'h0042, START with BCDIN = 16'h12A4 -> DONE 2 cycles after START, ERR = 1, BINOUT still 14'd42. A following valid request (16'h0500) -> ERR = 0, BINOUT = 500.
- START with BCDIN = 16'h0789, then pulse START with BCDIN = 16'h9999 and change BCDIN mid-conversion -> only one DONE; BINOUT = 789.
- Assert RST = 0 for one cycle at clock 10 of a 16'h5555 conversion -> all outputs 0 and no DONE. A new START with 16'h0100 then yields BINOUT = 100 after 30 clocks.
- Randomized sweep of all valid 4-digit BCD values against a decimal reference model, including START held high for back-to-back operation -> every result matches, with DONE period 31 cycles.
